// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared types and default sizes for the PC next-address logic.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    localparam int C_PC_WIDTH    = 8;
    localparam int C_STACK_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack
// Description : LIFO return-address stack with occupancy count and a
//               synchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module ret_stack
    import pc_sequencer_pkg::*;
#(
    parameter int D     = C_PC_WIDTH,
    parameter int DEPTH = C_STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [D-1:0]               push_data,
    output logic [D-1:0]               top,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     depth
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] C_FULL    = DW'(DEPTH);
    localparam logic [DW-1:0] C_ONE     = DW'(1);
    localparam logic [AW-1:0] C_IDX_ONE = AW'(1);

    logic [D-1:0]  mem_q [DEPTH];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign full     = (depth_q == C_FULL);
    assign empty    = (depth_q == '0);
    assign depth    = depth_q;
    // Index wraps to 0 when full, but writes are blocked in that case.
    assign w_wr_idx = depth_q[AW-1:0];
    assign w_rd_idx = w_wr_idx - C_IDX_ONE;
    assign top      = empty ? '0 : mem_q[w_rd_idx];

    always_comb begin
        depth_d = depth_q;
        if (push && !full) begin
            depth_d = depth_q + C_ONE;
        end else if (pop && !empty) begin
            depth_d = depth_q - C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push && !full) begin
            mem_q[w_wr_idx] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Next-address controller feeding branch/target to the PC
//               register; handles run/stall/branch/call/return/halt.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int D     = C_PC_WIDTH,
    parameter int DEPTH = C_STACK_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [D-1:0]            prog_ctr,
    input  logic                    start,
    input  logic                    br_taken,
    input  logic                    br_abs,
    input  logic [D-1:0]            br_imm,
    input  logic                    call,
    input  logic                    ret,
    input  logic                    stall,
    input  logic                    halt_req,
    output logic                    branch,
    output logic [D-1:0]            target,
    output logic                    fetch_en,
    output logic                    halted,
    output logic                    stk_err,
    output logic [$clog2(DEPTH):0]  stk_depth
);

    localparam logic [D-1:0] C_ONE = D'(1);

    state_t         state_q;
    state_t         state_d;
    logic           err_q;
    logic           err_d;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [D-1:0]   w_top;
    logic [D-1:0]   w_pc_inc;

    assign w_pc_inc = prog_ctr + C_ONE;
    assign stk_err  = err_q;

    ret_stack #(
        .D     (D),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top       (w_top),
        .full      (w_full),
        .empty     (w_empty),
        .depth     (stk_depth)
    );

    // Default everywhere is "hold": reload the PC with its own value.
    always_comb begin
        branch   = 1'b1;
        target   = prog_ctr;
        fetch_en = 1'b0;
        halted   = (state_q == ST_HALT);
        w_push   = 1'b0;
        w_pop    = 1'b0;
        state_d  = state_q;
        err_d    = err_q;

        if (!reset) begin
            target = '0;
            halted = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (stall) begin
                        state_d = ST_RUN;
                    end else if (ret) begin
                        if (w_empty) begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            target   = w_top;
                            w_pop    = 1'b1;
                            fetch_en = 1'b1;
                        end
                    end else if (call) begin
                        if (w_full) begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            target   = br_imm;
                            w_push   = 1'b1;
                            fetch_en = 1'b1;
                        end
                    end else if (br_taken) begin
                        target   = br_abs ? br_imm : (prog_ctr + br_imm);
                        fetch_en = 1'b1;
                    end else begin
                        branch   = 1'b0;
                        target   = w_pc_inc;
                        fetch_en = 1'b1;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Scoreboard bench for pc_sequencer (D=8, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [6:0] FS  = 7'h40;  // start
    localparam logic [6:0] FB  = 7'h20;  // br_taken
    localparam logic [6:0] FA  = 7'h10;  // br_abs
    localparam logic [6:0] FC  = 7'h08;  // call
    localparam logic [6:0] FR  = 7'h04;  // ret
    localparam logic [6:0] FST = 7'h02;  // stall
    localparam logic [6:0] FH  = 7'h01;  // halt_req

    logic       clk;
    logic       reset;
    logic [7:0] prog_ctr;
    logic       start, br_taken, br_abs, call, ret, stall, halt_req;
    logic [7:0] br_imm;
    logic       branch;
    logic [7:0] target;
    logic       fetch_en, halted, stk_err;
    logic [2:0] stk_depth;

    pc_sequencer #(.D(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_ctr  (prog_ctr),
        .start     (start),
        .br_taken  (br_taken),
        .br_abs    (br_abs),
        .br_imm    (br_imm),
        .call      (call),
        .ret       (ret),
        .stall     (stall),
        .halt_req  (halt_req),
        .branch    (branch),
        .target    (target),
        .fetch_en  (fetch_en),
        .halted    (halted),
        .stk_err   (stk_err),
        .stk_depth (stk_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] pc;
        logic [6:0] fl;
        logic [7:0] imm;
    } stim_t;

    typedef struct {
        string       name;
        logic [14:0] v;   // {branch, target, fetch_en, halted, stk_err, depth}
    } exp_t;

    stim_t stq[$];
    exp_t  sb[$];
    int    n_run  = 0;
    int    n_fail = 0;

    task automatic add(input string name, input logic rst, input logic [7:0] pc,
                       input logic [6:0] fl, input logic [7:0] imm,
                       input logic eb, input logic [7:0] et, input logic ef,
                       input logic eh, input logic ee, input logic [2:0] ed);
        stq.push_back('{rst, pc, fl, imm});
        sb.push_back('{name, {eb, et, ef, eh, ee, ed}});
    endtask

    task automatic apply(input stim_t s);
        reset    = s.rst;
        prog_ctr = s.pc;
        start    = s.fl[6];
        br_taken = s.fl[5];
        br_abs   = s.fl[4];
        call     = s.fl[3];
        ret      = s.fl[2];
        stall    = s.fl[1];
        halt_req = s.fl[0];
        br_imm   = s.imm;
    endtask

    task automatic test_reset();
        add("rst_hold0",  1'b0, 8'h37, 7'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        add("rst_hold1",  1'b0, 8'h37, 7'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        add("idle_hold",  1'b1, 8'h37, 7'h00, 8'h00, 1'b1, 8'h37, 1'b0, 1'b0, 1'b0, 3'd0);
        add("idle_br",    1'b1, 8'h37, FB,    8'h10, 1'b1, 8'h37, 1'b0, 1'b0, 1'b0, 3'd0);
        while (stq.size() != 0) begin
            exp_t e;
            logic [14:0] obs;
            apply(stq.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            obs = {branch, target, fetch_en, halted, stk_err, stk_depth};
            n_run++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: actual {b,t,f,h,e,d}=%h required %h", e.name, obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_run();
        add("idle_start", 1'b1, 8'h00, FS,      8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        add("seq0",       1'b1, 8'h00, 7'h00,   8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 3'd0);
        add("seq1",       1'b1, 8'h01, 7'h00,   8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 3'd0);
        add("seq2",       1'b1, 8'h02, 7'h00,   8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 3'd0);
        add("seq3",       1'b1, 8'h03, 7'h00,   8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 3'd0);
        add("br_rel_neg", 1'b1, 8'h10, FB,      8'hFC, 1'b1, 8'h0C, 1'b1, 1'b0, 1'b0, 3'd0);
        add("br_rel_wrap",1'b1, 8'hFE, FB,      8'h05, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 3'd0);
        add("br_abs",     1'b1, 8'h40, FB | FA, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 3'd0);
        add("start_run",  1'b1, 8'h41, FS,      8'h00, 1'b0, 8'h42, 1'b1, 1'b0, 1'b0, 3'd0);
        while (stq.size() != 0) begin
            exp_t e;
            logic [14:0] obs;
            apply(stq.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            obs = {branch, target, fetch_en, halted, stk_err, stk_depth};
            n_run++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: actual {b,t,f,h,e,d}=%h required %h", e.name, obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_call_ret();
        add("call",       1'b1, 8'h20, FC,      8'h80, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 3'd0);
        add("after_call", 1'b1, 8'h80, 7'h00,   8'h00, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 3'd1);
        add("ret",        1'b1, 8'h85, FR,      8'h00, 1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 3'd1);
        add("after_ret",  1'b1, 8'h21, 7'h00,   8'h00, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 3'd0);
        add("call2",      1'b1, 8'h30, FC,      8'h90, 1'b1, 8'h90, 1'b1, 1'b0, 1'b0, 3'd0);
        add("call_and_ret",1'b1,8'h90, FC | FR, 8'h44, 1'b1, 8'h31, 1'b1, 1'b0, 1'b0, 3'd1);
        add("after_both", 1'b1, 8'h31, 7'h00,   8'h00, 1'b0, 8'h32, 1'b1, 1'b0, 1'b0, 3'd0);
        while (stq.size() != 0) begin
            exp_t e;
            logic [14:0] obs;
            apply(stq.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            obs = {branch, target, fetch_en, halted, stk_err, stk_depth};
            n_run++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: actual {b,t,f,h,e,d}=%h required %h", e.name, obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_halt();
        add("call_s",     1'b1, 8'h50, FC,             8'h60, 1'b1, 8'h60, 1'b1, 1'b0, 1'b0, 3'd0);
        add("stall_br_call",1'b1,8'h60, FST | FB | FC, 8'h77, 1'b1, 8'h60, 1'b0, 1'b0, 1'b0, 3'd1);
        add("stall_ret",  1'b1, 8'h60, FST | FR,       8'h00, 1'b1, 8'h60, 1'b0, 1'b0, 1'b0, 3'd1);
        add("ret_s",      1'b1, 8'h60, FR,             8'h00, 1'b1, 8'h51, 1'b1, 1'b0, 1'b0, 3'd1);
        add("after_ret_s",1'b1, 8'h51, 7'h00,          8'h00, 1'b0, 8'h52, 1'b1, 1'b0, 1'b0, 3'd0);
        add("halt_stall", 1'b1, 8'h51, FH | FST | FB | FC, 8'h10, 1'b1, 8'h51, 1'b0, 1'b0, 1'b0, 3'd0);
        add("halt_start", 1'b1, 8'h51, FS,             8'h00, 1'b1, 8'h51, 1'b0, 1'b1, 1'b0, 3'd0);
        add("halt_br",    1'b1, 8'h52, FB,             8'h10, 1'b1, 8'h52, 1'b0, 1'b1, 1'b0, 3'd0);
        add("halt_rst",   1'b0, 8'h52, 7'h00,          8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        add("halt_restart",1'b1,8'h00, FS,             8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        while (stq.size() != 0) begin
            exp_t e;
            logic [14:0] obs;
            apply(stq.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            obs = {branch, target, fetch_en, halted, stk_err, stk_depth};
            n_run++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: actual {b,t,f,h,e,d}=%h required %h", e.name, obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stack_errors();
        add("nest1",      1'b1, 8'h10, FC,      8'h20, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 3'd0);
        add("nest2",      1'b1, 8'h20, FC,      8'h30, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 3'd1);
        add("nest3",      1'b1, 8'h30, FC,      8'h40, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 3'd2);
        add("nest4",      1'b1, 8'h40, FC,      8'h50, 1'b1, 8'h50, 1'b1, 1'b0, 1'b0, 3'd3);
        add("ovf",        1'b1, 8'h50, FC,      8'h60, 1'b1, 8'h50, 1'b0, 1'b0, 1'b0, 3'd4);
        add("ovf_start",  1'b1, 8'h50, FS,      8'h00, 1'b1, 8'h50, 1'b0, 1'b1, 1'b1, 3'd4);
        add("ovf_ret",    1'b1, 8'h50, FR,      8'h00, 1'b1, 8'h50, 1'b0, 1'b1, 1'b1, 3'd4);
        add("ovf_rst",    1'b0, 8'h50, 7'h00,   8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4);
        add("ovf_restart",1'b1, 8'h00, FS,      8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        add("udf",        1'b1, 8'h07, FC | FR, 8'hAA, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 3'd0);
        add("udf_halted", 1'b1, 8'h07, 7'h00,   8'h00, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 3'd0);
        add("udf_rst",    1'b0, 8'h07, 7'h00,   8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0);
        add("udf_restart",1'b1, 8'h00, FS,      8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        while (stq.size() != 0) begin
            exp_t e;
            logic [14:0] obs;
            apply(stq.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            obs = {branch, target, fetch_en, halted, stk_err, stk_depth};
            n_run++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: actual {b,t,f,h,e,d}=%h required %h", e.name, obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        add("mid_call1",  1'b1, 8'hA0, FC,    8'hB0, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 3'd0);
        add("mid_call2",  1'b1, 8'hB0, FC,    8'hC0, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 3'd1);
        add("mid_call3",  1'b1, 8'hC0, FC,    8'hD0, 1'b1, 8'hD0, 1'b1, 1'b0, 1'b0, 3'd2);
        add("mid_depth3", 1'b1, 8'hD0, 7'h00, 8'h00, 1'b0, 8'hD1, 1'b1, 1'b0, 1'b0, 3'd3);
        add("mid_rst",    1'b0, 8'hD0, FC,    8'hE0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3);
        add("mid_idle",   1'b1, 8'hD0, 7'h00, 8'h00, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b0, 3'd0);
        add("mid_start",  1'b1, 8'hD0, FS,    8'h00, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b0, 3'd0);
        add("mid_ret_udf",1'b1, 8'hD0, FR,    8'h00, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b0, 3'd0);
        add("mid_halted", 1'b1, 8'hD0, 7'h00, 8'h00, 1'b1, 8'hD0, 1'b0, 1'b1, 1'b1, 3'd0);
        while (stq.size() != 0) begin
            exp_t e;
            logic [14:0] obs;
            apply(stq.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            obs = {branch, target, fetch_en, halted, stk_err, stk_depth};
            n_run++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: actual {b,t,f,h,e,d}=%h required %h", e.name, obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_run();
        test_call_ret();
        test_stall_halt();
        test_stack_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-address controller that drives the program counter's `branch`/`target` inputs every cycle.
- Sequences fetch: start/idle, sequential run, stall, relative/absolute branches, call/return through a small return-address stack, and halt.
- Sits between decode/hazard logic and the PC register, combinational toward the PC with its own registered state.
- All PC updates happen at the PC's next clock edge from the branch/target values presented here.

Parameters:
- D, 8, program counter / address width.
- DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- prog_ctr  input  D  current PC value.
- start  input  1  leave IDLE and begin fetching.
- br_taken  input  1  branch taken this cycle.
- br_abs  input  1  1 = absolute target br_imm; 0 = relative prog_ctr+br_imm.
- br_imm  input  D  branch offset (two's complement) or absolute address; call target (always absolute).
- call  input  1  push return address, jump to br_imm.
- ret  input  1  pop return address, jump to it.
- stall  input  1  hold PC this cycle.
- halt_req  input  1  stop fetching permanently (until reset).
- branch  output  1  to PC: load target.
- target  output  D  to PC: next address when branch=1.
- fetch_en  output  1  instruction at prog_ctr is valid this cycle.
- halted  output  1  state == HALT.
- stk_err  output  1  sticky stack overflow/underflow flag.
- stk_depth  output  $clog2(DEPTH)+1  current stack occupancy.

Behaviour:
- States:
  - IDLE (reset state): hold PC; go to RUN when start=1.
  - RUN: normal fetch.
  - HALT: hold PC; exit only by reset; start ignored.
- Reset (reset=0), including mid-operation: state←IDLE, stack cleared (stk_depth=0), stk_err←0. While reset=0, outputs are combinationally forced to branch=1, target=0, fetch_en=0, halted=0.
- Hold = branch=1, target=prog_ctr.
- IDLE and HALT: always hold; fetch_en=0.
- RUN priority, highest first:
  1. halt_req: hold, fetch_en=0, next state HALT.
  2. stall: hold, fetch_en=0, stack unchanged.
  3. ret:
     - If stack empty: underflow, hold, stk_err←1, next state HALT.
     - Else: target=top, branch=1, pop.
  4. call:
     - If stack full: overflow, hold, stk_err←1, next state HALT.
     - Else: push prog_ctr+1 (mod 2^D), target=br_imm, branch=1.
  5. br_taken: branch=1; target=br_imm if br_abs=1, else prog_ctr+br_imm (mod 2^D, offset sign-extended to D, wraps).
  6. Otherwise: branch=0, target=prog_ctr+1 (don't-care to PC).
- fetch_en=1 in RUN unless halt_req, stall, or a stack error occurs this cycle.
- Simultaneous call+ret: ret wins; call is ignored.
- Stack push/pop and state changes are registered on posedge clk. Outputs are combinational from state, stack top, and inputs, giving zero-cycle latency to the PC.
- Stack is LIFO with a pointer; push and pop never occur in the same cycle.

Decomposition:
- Shared package (e.g. cpu_pkg): state enum {IDLE, RUN, HALT}, default PC width constant.
- One sub-module: ret_stack (push, pop, push_data, top, full, empty, depth; synchronous active-low clear).

Test Plan:
- Reset with reset=0 for 2 cycles, prog_ctr=0x37 → branch=1, target=0x00, stk_depth=0, halted=0. Release without start → branch=1, target=prog_ctr, fetch_en=0.
- start, then 3 idle cycles from PC=0 → branch=0, fetch_en=1, PC reaches 0x03. At PC=0x10, br_taken=1, br_abs=0, br_imm=0xFC → target=0x0C. At PC=0xFE, br_imm=0x05 relative → target=0x03 (wrap).
- At PC=0x20, call with br_imm=0x80 → target=0x80, stk_depth=1. Then ret at 0x85 → target=0x21, stk_depth=0.
- Four nested calls (depth 4), then a fifth call → hold, stk_err=1, halted=1 next cycle; start afterwards has no effect. Separately, ret with empty stack → stk_err=1, HALT.
- stall=1 with br_taken=1 and call=1 → branch=1, target=prog_ctr, stk_depth unchanged, fetch_en=0. Same cycle with halt_req=1 → HALT.
- reset=0 asserted mid-run with stk_depth=3 → next cycle IDLE, stk_depth=0, stk_err=0.
